l2_request_scheduler: RTL and testbench
=======================================

# l2_request_scheduler

Front-end scheduler for the L2 cache pipeline. Selects at most one request per cycle from the per-core L2 request ports and the L2 restart (memory fill / restarted flush) path, then registers the winner into the first pipeline stage. Restarts take priority because they retire misses; a bounded-burst rule keeps cores from starving. Downstream back-pressure freezes selection and output.

## Interface
Parameters:
- NUM_REQUESTERS, default `CORE_COUNT: number of core request ports, 1 to 16.
- RESTART_BURST_LIMIT, default 8: consecutive restart grants allowed while any core is waiting, 1 to 255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- core_request_valid  in  NUM_REQUESTERS  per-core request pending
- core_request  in  l2req_packet_t[NUM_REQUESTERS]  per-core request packet
- core_request_ready  out  NUM_REQUESTERS  per-core accept; combinational
- restart_valid  in  1  restart request pending
- restart_request  in  l2req_packet_t  restart packet
- restart_is_flush  in  1  restart is a flush second pass, not a fill
- restart_data  in  cache_line_data_t  line data from memory, for fills
- restart_ready  out  1  restart accept; combinational
- pipeline_stall  in  1  downstream cannot accept this cycle
- sched_request_valid  out  1  output slot holds a valid request
- sched_request  out  l2req_packet_t  granted packet
- sched_is_l2_fill  out  1  granted item is a restart fill
- sched_is_restarted_flush  out  1  granted item is a restarted flush
- sched_data_from_memory  out  cache_line_data_t  fill data; zero for core grants

## Operation
- A request transfers when its valid and ready are both 1 in the same cycle.
- Requesters hold valid and payload stable until ready. Ready does not depend on the same requester's valid.
- Grant decision, evaluated only when pipeline_stall=0:
  - No requests pending: no grant.
  - Only restart pending: grant restart.
  - Only cores pending: grant the round-robin winner.
  - Both pending: grant restart if burst_count < RESTART_BURST_LIMIT; otherwise grant the round-robin core.
- Readiness: restart_ready = grant_restart && !pipeline_stall. core_request_ready[i] = grant_core[i] && !pipeline_stall. At most one ready is 1 per cycle.
- Round robin: rr_ptr is the highest-priority core index. After a core grant to index i, rr_ptr = (i+1) mod NUM_REQUESTERS. rr_ptr does not change on restart grants or idle cycles.
- burst_count (8 bits):
  - On a restart grant with any core valid: increment, saturating at RESTART_BURST_LIMIT.
  - On a core grant, or on any cycle with no core valid: clear to 0.
- Output register, loaded when pipeline_stall=0:
  - sched_request_valid <= any grant.
  - Payload <= winner's fields. sched_is_l2_fill = restart && !restart_is_flush. sched_is_restarted_flush = restart && restart_is_flush.
  - With no grant, valid goes to 0 and the payload keeps its previous value.
- Stall: when pipeline_stall=1, all readies are 0, and every output, rr_ptr and burst_count hold.
- Reset (asynchronous): sched_request_valid=0, sched_is_l2_fill=0, sched_is_restarted_flush=0, sched_request=0, sched_data_from_memory=0, rr_ptr=0, burst_count=0. Readies are 0 while reset is asserted.
- Reset asserted mid-transfer drops the in-flight output. Requesters re-present after reset.
- Assertions:
  - Grants are one-hot or zero.
  - No ready is asserted while pipeline_stall=1.
  - sched_is_l2_fill and sched_is_restarted_flush are never both set.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on sched_* after edge N.
- Throughput is one request per cycle when not stalled.
- pipeline_stall has a combinational path to all readies. No other input-to-output combinational paths exist except valid to ready through the arbiter.
- Worst-case core wait with restarts continuously pending: RESTART_BURST_LIMIT × NUM_REQUESTERS + NUM_REQUESTERS − 1 grant cycles, excluding stall cycles.

## Structure
- l2req_packet_t, cache_line_data_t and `CORE_COUNT come from the shared defines package.
- No new shared typedefs. burst_count width is local.
- One sub-module: rr_arbiter, parameterised by NUM_REQUESTERS, with inputs request and update_lru and a one-hot grant_oh output. The scheduler drives update_lru = core grant && !pipeline_stall.
- The restart-versus-core choice, burst counter and output register live in the top level.

## Test plan
- Reset, then core 2 valid alone, no stall: core_request_ready[2]=1 that cycle; next cycle sched_request_valid=1 with core 2's id, sched_is_l2_fill=0, sched_data_from_memory=0.
- All 4 cores continuously valid, no restarts: grants in order 0,1,2,3,0,…; exactly one ready per cycle for 8 cycles.
- Restart valid with restart_is_flush=0 together with core 0 valid, limit 8: restart granted 8 consecutive cycles, core 0 granted on the 9th, then restart again. sched_is_l2_fill=1 and data matches on each restart output.
- pipeline_stall=1 for 3 cycles while cores 1 and 3 are valid: all readies 0 and sched_* unchanged for those cycles. On release, core 1 is granted first and rr_ptr is unchanged by the stall.
- Restart with restart_is_flush=1: sched_is_restarted_flush=1 and sched_is_l2_fill=0 on the output.
- Assert reset mid-stream while sched_request_valid=1: all outputs go to 0 immediately. After deassert, rr_ptr=0, so with all cores valid core 0 is granted first.

Source files
------------

// File: rtl/l2_request_scheduler_pkg.sv
// Shared L2 request types and the default core count used by the request scheduler.
`ifndef CORE_COUNT
`define CORE_COUNT 4
`endif

package l2_request_scheduler_pkg;

  typedef struct packed {
    logic [3:0]  core_id;
    logic [1:0]  opcode;
    logic [31:0] address;
  } l2req_packet_t;

  typedef logic [127:0] cache_line_data_t;

endpackage

// File: rtl/l2_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the pointer; pointer moves past the winner
// only when update_lru_i is set.
module l2_request_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQUESTERS-1:0] request_i,
  input  logic                      update_lru_i,
  output logic [NUM_REQUESTERS-1:0] grant_oh_o
);

  localparam int unsigned PtrW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] grant_idx;
  logic [PtrW:0]   cand;
  logic            found;

  always_comb begin
    grant_oh_o = '0;
    grant_idx  = '0;
    cand       = '0;
    found      = 1'b0;
    for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(NUM_REQUESTERS)) begin
        cand = cand - (PtrW+1)'(NUM_REQUESTERS);
      end
      if (!found && request_i[cand[PtrW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PtrW-1:0];
      end
    end
    if (found) begin
      grant_oh_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_lru_i && found) begin
      ptr_d = (grant_idx == PtrW'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/l2_request_scheduler.sv
// L2 pipeline front end: picks one of restart or a round-robin core each cycle and registers it.
// Restarts win until the burst limit is hit while cores wait; stall freezes everything.
`ifndef CORE_COUNT
`define CORE_COUNT 4
`endif

module l2_request_scheduler
  import l2_request_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS      = `CORE_COUNT,
  parameter int unsigned RESTART_BURST_LIMIT = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [NUM_REQUESTERS-1:0]                core_request_valid_i,
  input  l2req_packet_t [NUM_REQUESTERS-1:0]       core_request_i,
  output logic [NUM_REQUESTERS-1:0]                core_request_ready_o,
  input  logic                                     restart_valid_i,
  input  l2req_packet_t                            restart_request_i,
  input  logic                                     restart_is_flush_i,
  input  cache_line_data_t                         restart_data_i,
  output logic                                     restart_ready_o,
  input  logic                                     pipeline_stall_i,
  output logic                                     sched_request_valid_o,
  output l2req_packet_t                            sched_request_o,
  output logic                                     sched_is_l2_fill_o,
  output logic                                     sched_is_restarted_flush_o,
  output cache_line_data_t                         sched_data_from_memory_o
);

  localparam int unsigned BurstW = 8;
  localparam logic [BurstW-1:0] BurstLimit = BurstW'(RESTART_BURST_LIMIT);

  logic [BurstW-1:0]         burst_q, burst_d;
  logic                      any_core;
  logic                      grant_restart;
  logic                      grant_core;
  logic [NUM_REQUESTERS-1:0] arb_grant_oh;
  logic [NUM_REQUESTERS-1:0] grant_core_oh;
  l2req_packet_t             core_pkt;

  logic             valid_q, valid_d;
  l2req_packet_t    pkt_q, pkt_d;
  logic             fill_q, fill_d;
  logic             flush_q, flush_d;
  cache_line_data_t data_q, data_d;

  assign any_core      = |core_request_valid_i;
  assign grant_restart = restart_valid_i && (!any_core || (burst_q < BurstLimit));
  assign grant_core    = any_core && !grant_restart;
  assign grant_core_oh = grant_core ? arb_grant_oh : '0;

  // Readies also drop during reset so nothing transfers into a register being cleared.
  assign core_request_ready_o = (pipeline_stall_i || reset_i) ? '0 : grant_core_oh;
  assign restart_ready_o      = grant_restart && !pipeline_stall_i && !reset_i;

  l2_request_scheduler_rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .request_i   (core_request_valid_i),
    .update_lru_i(grant_core && !pipeline_stall_i),
    .grant_oh_o  (arb_grant_oh)
  );

  always_comb begin
    core_pkt = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (arb_grant_oh[i]) begin
        core_pkt = core_request_i[i];
      end
    end
  end

  // Count only restarts that actually made a core wait; anything else resets the burst.
  always_comb begin
    burst_d = burst_q;
    if (!pipeline_stall_i) begin
      if (grant_restart && any_core) begin
        if (burst_q < BurstLimit) begin
          burst_d = burst_q + 1'b1;
        end
      end else begin
        burst_d = '0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    fill_d  = fill_q;
    flush_d = flush_q;
    data_d  = data_q;
    if (!pipeline_stall_i) begin
      valid_d = grant_restart || grant_core;
      if (grant_restart) begin
        pkt_d   = restart_request_i;
        fill_d  = !restart_is_flush_i;
        flush_d = restart_is_flush_i;
        data_d  = restart_data_i;
      end else if (grant_core) begin
        pkt_d   = core_pkt;
        fill_d  = 1'b0;
        flush_d = 1'b0;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      burst_q <= '0;
      valid_q <= 1'b0;
      pkt_q   <= '0;
      fill_q  <= 1'b0;
      flush_q <= 1'b0;
      data_q  <= '0;
    end else begin
      burst_q <= burst_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      data_q  <= data_d;
    end
  end

  assign sched_request_valid_o      = valid_q;
  assign sched_request_o            = pkt_q;
  assign sched_is_l2_fill_o         = fill_q;
  assign sched_is_restarted_flush_o = flush_q;
  assign sched_data_from_memory_o   = data_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0({grant_core_oh, grant_restart}));
  a_no_ready_in_stall: assert property (@(posedge clk_i)
    pipeline_stall_i |-> (core_request_ready_o == '0 && !restart_ready_o));
  a_fill_flush_excl: assert property (@(posedge clk_i)
    !(sched_is_l2_fill_o && sched_is_restarted_flush_o));
`endif

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Randomised and directed bench for l2_request_scheduler against a rule-level reference model.
module tb_l2_request_scheduler;
  import l2_request_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int LIM = 8;
  localparam int RST = N;  // grant code for restart

  logic                      clk;
  logic                      rst;
  logic [N-1:0]              cv;
  l2req_packet_t [N-1:0]     cpk;
  logic [N-1:0]              crdy;
  logic                      rv;
  l2req_packet_t             rpk;
  logic                      rflush;
  cache_line_data_t          rdata;
  logic                      rrdy;
  logic                      stall;
  logic                      sv;
  l2req_packet_t             spk;
  logic                      sfill;
  logic                      sflush;
  cache_line_data_t          sdata;

  l2_request_scheduler #(
    .NUM_REQUESTERS     (N),
    .RESTART_BURST_LIMIT(LIM)
  ) dut (
    .clk_i                     (clk),
    .reset_i                   (rst),
    .core_request_valid_i      (cv),
    .core_request_i            (cpk),
    .core_request_ready_o      (crdy),
    .restart_valid_i           (rv),
    .restart_request_i         (rpk),
    .restart_is_flush_i        (rflush),
    .restart_data_i            (rdata),
    .restart_ready_o           (rrdy),
    .pipeline_stall_i          (stall),
    .sched_request_valid_o     (sv),
    .sched_request_o           (spk),
    .sched_is_l2_fill_o        (sfill),
    .sched_is_restarted_flush_o(sflush),
    .sched_data_from_memory_o  (sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int               m_rr;
  int               m_burst;
  logic             m_v;
  l2req_packet_t    m_pkt;
  logic             m_fill;
  logic             m_flush;
  cache_line_data_t m_data;
  int               last_grant;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_burst = 0; m_v = 1'b0; m_pkt = '0;
    m_fill = 1'b0; m_flush = 1'b0; m_data = '0; last_grant = -1;
  endtask

  function automatic int pick(input logic [N-1:0] c, input logic r, input logic s);
    logic [1:0] j;
    if (s) return -1;
    if (r && (c == '0 || m_burst < LIM)) return RST;
    for (int k = 0; k < N; k++) begin
      j = 2'((m_rr + k) % N);
      if (c[j]) return int'(j);
    end
    return -1;
  endfunction

  function automatic l2req_packet_t rand_pkt(input int id);
    l2req_packet_t p;
    p.core_id = (id >= 0) ? 4'(id) : 4'($urandom);
    p.opcode  = 2'($urandom);
    p.address = $urandom;
    return p;
  endfunction

  function automatic cache_line_data_t rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic tick();
    int g;
    logic [N-1:0] exp_c;
    #3;
    g = pick(cv, rv, stall);
    exp_c = (g >= 0 && g < N) ? N'(1 << g) : '0;
    check_eq("core_ready", crdy, exp_c);
    check_eq("restart_ready", rrdy, g == RST);
    if (!stall) begin
      if (g == RST) begin
        m_v = 1'b1; m_pkt = rpk; m_fill = !rflush; m_flush = rflush; m_data = rdata;
        m_burst = (cv != '0) ? ((m_burst < LIM) ? m_burst + 1 : LIM) : 0;
      end else if (g >= 0) begin
        m_v = 1'b1; m_pkt = cpk[g]; m_fill = 1'b0; m_flush = 1'b0; m_data = '0;
        m_rr = (g + 1) % N;
        m_burst = 0;
      end else begin
        m_v = 1'b0;
        m_burst = 0;
      end
    end
    last_grant = g;
    @(posedge clk);
    #1;
    check_eq("out_valid", sv, m_v);
    if (m_v) begin
      check_eq("out_pkt", spk, m_pkt);
      check_eq("out_fill", sfill, m_fill);
      check_eq("out_flush", sflush, m_flush);
      check_eq("out_data", sdata, m_data);
    end
  endtask

  task automatic idle_inputs();
    cv = '0; rv = 1'b0; rflush = 1'b0; stall = 1'b0; rdata = '0; rpk = '0;
    for (int i = 0; i < N; i++) cpk[i] = rand_pkt(i);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Re-present new traffic only for requesters whose item was accepted on the last tick.
  task automatic refresh_restart(input logic keep_valid, input logic flush);
    if (last_grant == RST || !rv) begin
      rv = keep_valid; rflush = flush; rpk = rand_pkt(-1); rdata = rand_data();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cv = '1; rv = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_valid", sv, 1'b0);
    check_eq("rst_pkt", spk, '0);
    check_eq("rst_fill", sfill, 1'b0);
    check_eq("rst_flush", sflush, 1'b0);
    check_eq("rst_data", sdata, '0);
    check_eq("rst_core_ready", crdy, '0);
    check_eq("rst_restart_ready", rrdy, 1'b0);
    rst = 1'b0;
    idle_inputs();

    // Core 2 alone
    cv = 4'b0100;
    tick();
    check_eq("c2_grant", last_grant, 2);
    check_eq("c2_id", spk.core_id, 4'd2);
    cv = '0;
    tick();

    // All cores: strict rotation from 0
    apply_reset();
    cv = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq("rr_order", last_grant, k % N);
      cpk[last_grant] = rand_pkt(last_grant);
    end

    // Restart fill burst vs core 0
    apply_reset();
    cv = 4'b0001;
    rv = 1'b1; rflush = 1'b0; rpk = rand_pkt(-1); rdata = rand_data();
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("burst_order", last_grant, (k % 9 == 8) ? 0 : RST);
      if (last_grant == 0) cpk[0] = rand_pkt(0);
      refresh_restart(1'b1, 1'b0);
    end

    // Stall with cores 1 and 3 waiting
    apply_reset();
    cv = 4'b1000;
    tick();
    cv = 4'b1010; cpk[3] = rand_pkt(3); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("stall_id", spk.core_id, 4'd3);
    end
    stall = 1'b0;
    tick();
    check_eq("post_stall_grant", last_grant, 1);

    // Restarted flush
    apply_reset();
    rv = 1'b1; rflush = 1'b1; rpk = rand_pkt(-1); rdata = rand_data();
    tick();
    check_eq("flush_bit", sflush, 1'b1);
    check_eq("flush_fill", sfill, 1'b0);
    rv = 1'b0;

    // Reset mid-stream
    apply_reset();
    cv = '1;
    tick();
    check_eq("pre_rst_valid", sv, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", sv, 1'b0);
    check_eq("mid_rst_pkt", spk, '0);
    check_eq("mid_rst_fill", sfill, 1'b0);
    check_eq("mid_rst_flush", sflush, 1'b0);
    check_eq("mid_rst_data", sdata, '0);
    check_eq("mid_rst_core_ready", crdy, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cv = '1;
    tick();
    check_eq("post_rst_first", last_grant, 0);

    // Random traffic with hold-until-accepted requesters
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!cv[i] || last_grant == i) begin
          cv[i]  = ($urandom % 2) == 0;
          cpk[i] = rand_pkt(i);
        end
      end
      refresh_restart(($urandom % 3) != 0, ($urandom % 2) == 0);
      stall = ($urandom % 5) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
